// File: rtl/lsu_data_port.sv
// Load/store bus master: one req/gnt/rvalid data-memory transaction per MEM-stage access.
// Optional build macro MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
package lsu_pkg;
    typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2} memaccess_t;
    typedef enum logic [2:0] {BYTE = 3'd0, BYTE_U = 3'd1, HALF = 3'd2, HALF_U = 3'd3, WORD = 3'd4} mask_mode_t;
endpackage

module lsu_data_port
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  memaccess_t  memaccess,
    input  mask_mode_t  mask_mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] rdata_raw,
    output logic [1:0]  addr_offset,
    output logic        bus_err,
    output logic        misalign_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    off_q, off_d;
    logic          mis_q, mis_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          is_access, is_write, misalign, timeout;
    logic [1:0]    off;
    logic [3:0]    be_sel;
    logic [31:0]   wdata_sel;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        is_access = mem_valid && (memaccess == MEM_READ || memaccess == MEM_WRITE);
        is_write  = (memaccess == MEM_WRITE);
        off       = addr[1:0];
        be_sel    = 4'b1111 << off;
        wdata_sel = wdata;
        case (mask_mode)
            BYTE, BYTE_U: begin
                be_sel    = 4'b0001 << off;
                wdata_sel = {4{wdata[7:0]}};
            end
            HALF, HALF_U: begin
                be_sel    = 4'b0011 << off;
                wdata_sel = {2{wdata[15:0]}};
            end
            default: ;
        endcase
`ifdef MISALIGN_TRAP_EN
        misalign = ((mask_mode == HALF || mask_mode == HALF_U) && off[0])
                || (mask_mode == WORD && off != 2'b00);
`else
        misalign = 1'b0;
`endif
        timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES));

        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        off_d        = off_q;
        mis_d        = mis_q;
        cnt_d        = (state_q != IDLE) ? cnt_q + 1'b1 : cnt_q;
        lsu_done     = 1'b0;
        bus_err      = 1'b0;
        misalign_err = 1'b0;
        rdata_raw    = 32'h0;

        case (state_q)
            IDLE: begin
                if (is_access) begin
                    state_d = REQ;
                    req_d   = !misalign;
                    we_d    = is_write;
                    be_d    = is_write ? be_sel : 4'b0000;
                    addr_d  = {addr[31:2], 2'b00};
                    wdata_d = is_write ? wdata_sel : 32'h0;
                    off_d   = off;
                    mis_d   = misalign;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (mis_q) begin
                    lsu_done     = 1'b1;
                    misalign_err = 1'b1;
                    state_d      = IDLE;
                end else if (dmem_gnt) begin
                    // A grant in the timeout cycle still wins.
                    req_d = 1'b0;
                    if (we_q) begin
                        lsu_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (timeout) begin
                    req_d    = 1'b0;
                    lsu_done = 1'b1;
                    bus_err  = 1'b1;
                    state_d  = IDLE;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    lsu_done  = 1'b1;
                    rdata_raw = dmem_rdata;
                    state_d   = IDLE;
                end else if (timeout) begin
                    lsu_done = 1'b1;
                    bus_err  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        lsu_stall = is_access && !lsu_done;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            off_q   <= 2'b00;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_be     = be_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign addr_offset = off_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Scoreboard bench for lsu_data_port: expected completions are queued at issue and popped on lsu_done.
// Runs with a short timeout so the bus-error path and its boundary are reachable quickly.
module tb_lsu_data_port;
    import lsu_pkg::*;

    localparam int TMO = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    memaccess_t  memaccess = MEM_NONE;
    mask_mode_t  mask_mode = WORD;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        lsu_stall, lsu_done, bus_err, misalign_err;
    logic [31:0] rdata_raw;
    logic [1:0]  addr_offset;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        we;
        logic        req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  off;
        logic        berr;
        logic        merr;
        int          done_at;
    } exp_t;

    exp_t exp_q[$];

    lsu_data_port #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .memaccess(memaccess),
        .mask_mode(mask_mode), .addr(addr), .wdata(wdata), .lsu_stall(lsu_stall),
        .lsu_done(lsu_done), .rdata_raw(rdata_raw), .addr_offset(addr_offset),
        .bus_err(bus_err), .misalign_err(misalign_err), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Cycle 0 is the capture cycle; gm/rm give the cycles in which gnt/rvalid are driven.
    task automatic run_acc(input string tag, input memaccess_t ma, input mask_mode_t mm,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] gm, input logic [31:0] rm, input logic [31:0] rd,
                           input logic [3:0] be_e, input logic [31:0] wd_e, input logic req_e,
                           input int done_e, input logic berr_e, input logic merr_e);
        exp_t e;
        exp_t got_e;
        bit   seen;
        e.we      = (ma == MEM_WRITE);
        e.req     = req_e;
        e.addr    = {a[31:2], 2'b00};
        e.be      = be_e;
        e.wdata   = wd_e;
        e.rdata   = (berr_e || merr_e) ? 32'h0 : rd;
        e.off     = a[1:0];
        e.berr    = berr_e;
        e.merr    = merr_e;
        e.done_at = done_e;
        exp_q.push_back(e);

        @(posedge clk); #1;
        mem_valid   = 1'b1;
        memaccess   = ma;
        mask_mode   = mm;
        addr        = a;
        wdata       = wd;
        dmem_rdata  = rd;
        dmem_gnt    = gm[0];
        dmem_rvalid = rm[0];
        seen = 1'b0;
        for (int cyc = 0; cyc < 32 && !seen; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                dmem_gnt    = gm[cyc];
                dmem_rvalid = rm[cyc];
            end
            @(negedge clk);
            if (cyc == 0) begin
                check({tag, " stall_at_capture"}, 32'(lsu_stall), 32'd1);
                check({tag, " req_at_capture"}, 32'(dmem_req), 32'd0);
            end
            if (cyc == 1) check({tag, " req_first"}, 32'(dmem_req), 32'(e.req));
            if (dmem_req) begin
                check({tag, " dmem_addr"}, dmem_addr, e.addr);
                check({tag, " dmem_be"}, 32'(dmem_be), 32'(e.be));
                check({tag, " dmem_wdata"}, dmem_wdata, e.wdata);
                check({tag, " dmem_we"}, 32'(dmem_we), 32'(e.we));
            end
            if (lsu_done) begin
                seen  = 1'b1;
                got_e = exp_q.pop_front();
                check({tag, " done_cycle"}, 32'(cyc), 32'(got_e.done_at));
                check({tag, " bus_err"}, 32'(bus_err), 32'(got_e.berr));
                check({tag, " misalign_err"}, 32'(misalign_err), 32'(got_e.merr));
                check({tag, " addr_offset"}, 32'(addr_offset), 32'(got_e.off));
                check({tag, " stall_at_done"}, 32'(lsu_stall), 32'd0);
                if (!got_e.we) check({tag, " rdata_raw"}, rdata_raw, got_e.rdata);
            end
        end
        if (!seen) begin
            check({tag, " done_within_budget"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        mem_valid   = 1'b0;
        memaccess   = MEM_NONE;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset dmem_req", 32'(dmem_req), 32'd0);
        check("reset dmem_we", 32'(dmem_we), 32'd0);
        check("reset dmem_be", 32'(dmem_be), 32'd0);
        check("reset dmem_addr", dmem_addr, 32'd0);
        check("reset dmem_wdata", dmem_wdata, 32'd0);
        check("reset addr_offset", 32'(addr_offset), 32'd0);
        check("reset lsu_done", 32'(lsu_done), 32'd0);
        check("reset lsu_stall", 32'(lsu_stall), 32'd0);
        #5 rst_n = 1'b1;

        //       tag          acc        mode    addr          wdata         gnt_mask  rv_mask   rdata         be       wdata_exp     req done berr merr
        run_acc("sw_word",   MEM_WRITE, WORD,   32'h0000_0100, 32'hDEAD_BEEF, 32'h2,  32'h0,  32'h0,        4'hF,    32'hDEAD_BEEF, 1, 1, 0, 0);
        run_acc("sb_103",    MEM_WRITE, BYTE,   32'h0000_0103, 32'h0000_00A5, 32'h2,  32'h0,  32'h0,        4'b1000, 32'hA5A5_A5A5, 1, 1, 0, 0);
        run_acc("sh_206",    MEM_WRITE, HALF,   32'h0000_0206, 32'h1234_BEEF, 32'h4,  32'h0,  32'h0,        4'b1100, 32'hBEEF_BEEF, 1, 2, 0, 0);
        run_acc("lh_202",    MEM_READ,  HALF,   32'h0000_0202, 32'h0,         32'h10, 32'h40, 32'h1234_5678, 4'h0,   32'h0,         1, 6, 0, 0);
        run_acc("lw_rv_gnt", MEM_READ,  WORD,   32'h0000_0300, 32'h0,         32'h2,  32'hA,  32'h0BAD_F00D, 4'h0,   32'h0,         1, 3, 0, 0);
        run_acc("lbu_rv_req",MEM_READ,  BYTE_U, 32'h0000_0301, 32'h0,         32'h8,  32'h24, 32'hCAFE_F00D, 4'h0,   32'h0,         1, 5, 0, 0);
        run_acc("lw_tmo",    MEM_READ,  WORD,   32'h0000_0400, 32'h0,         32'h0,  32'h0,  32'h5555_AAAA, 4'h0,   32'h0,         1, 7, 1, 0);
        run_acc("sw_gnt_tmo",MEM_WRITE, WORD,   32'h0000_0404, 32'h0102_0304, 32'h80, 32'h0,  32'h0,        4'hF,    32'h0102_0304, 1, 7, 0, 0);
        run_acc("lw_rv_tmo", MEM_READ,  WORD,   32'h0000_0408, 32'h0,         32'h2,  32'h80, 32'h7777_1111, 4'h0,   32'h0,         1, 7, 0, 0);
`ifdef MISALIGN_TRAP_EN
        run_acc("lw_101",    MEM_READ,  WORD,   32'h0000_0101, 32'h0,         32'h2,  32'h4,  32'h9999_0000, 4'h0,   32'h0,         0, 1, 0, 1);
        run_acc("sw_101",    MEM_WRITE, WORD,   32'h0000_0101, 32'h1122_3344, 32'h2,  32'h0,  32'h0,        4'h0,    32'h0,         0, 1, 0, 1);
        run_acc("sh_207",    MEM_WRITE, HALF,   32'h0000_0207, 32'h0000_ABCD, 32'h2,  32'h0,  32'h0,        4'h0,    32'h0,         0, 1, 0, 1);
`else
        run_acc("lw_101",    MEM_READ,  WORD,   32'h0000_0101, 32'h0,         32'h2,  32'h4,  32'h9999_0000, 4'h0,   32'h0,         1, 2, 0, 0);
        run_acc("sw_101",    MEM_WRITE, WORD,   32'h0000_0101, 32'h1122_3344, 32'h2,  32'h0,  32'h0,        4'b1110, 32'h1122_3344, 1, 1, 0, 0);
        run_acc("sh_207",    MEM_WRITE, HALF,   32'h0000_0207, 32'h0000_ABCD, 32'h2,  32'h0,  32'h0,        4'b1000, 32'hABCD_ABCD, 1, 1, 0, 0);
`endif

        // Abandon a read in WAIT_R with reset; a late rvalid must not complete anything.
        @(posedge clk); #1;
        mem_valid = 1'b1;
        memaccess = MEM_READ;
        mask_mode = WORD;
        addr      = 32'h0000_0503;
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        check("rst_wait lsu_done_before", 32'(lsu_done), 32'd0);
        mem_valid = 1'b0;
        memaccess = MEM_NONE;
        rst_n     = 1'b0;
        #1;
        check("rst_wait dmem_req", 32'(dmem_req), 32'd0);
        check("rst_wait addr_offset", 32'(addr_offset), 32'd0);
        check("rst_wait lsu_stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_0000;
        @(negedge clk);
        check("rst_wait late_rvalid_done", 32'(lsu_done), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        run_acc("lw_after_rst", MEM_READ, WORD, 32'h0000_0600, 32'h0, 32'h2, 32'h4, 32'h600D_600D, 4'h0, 32'h0, 1, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
